// File: rtl/frame_pkg.sv
// frame_pkg: shared frame descriptor layout, scheduler states and framing markers.
package frame_pkg;
    localparam int DESC_W = 140;
    localparam logic [31:0] HEADER = 32'hE0E0E0E0;
    localparam logic [31:0] TRAILER = 32'h0E0E0E0E;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_LAT   = 3'd2,
        S_CHK   = 3'd3,
        S_ISSUE = 3'd4,
        S_WAIT  = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    typedef struct packed {
        logic         crc_ok;
        logic [7:0]   chan;
        logic [2:0]   len_code;
        logic [127:0] payload;
    } frame_desc_t;
endpackage

// File: rtl/frame_desc_align.sv
// frame_desc_align: one-hot channel check, payload bit length and left-align shifter.
module frame_desc_align (
    input  logic [7:0]   chan,
    input  logic [2:0]   len_code,
    input  logic [127:0] payload,
    output logic         chan_ok,
    output logic [7:0]   ser_len,
    output logic [127:0] ser_data
);
    assign chan_ok = (chan != 8'd0) && ((chan & (chan - 8'd1)) == 8'd0);
    assign ser_len = {{1'b0, len_code} + 4'd1, 4'd0};
    // 128 - ser_len is (7 - len_code) * 16, i.e. ~len_code in 16-bit steps
    assign ser_data = payload << {~len_code, 4'd0};
endmodule

// File: rtl/frame_out_scheduler.sv
// frame_out_scheduler: pops descriptors, drops bad frames, issues to the serializer.
// Defining SCHED_STATS_EN adds saturating sent/dropped frame counters.
module frame_out_scheduler
    import frame_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 512,
    parameter int GAP_CYCLES = 2
) (
    input  logic         clk_out,
    input  logic         rst,
    input  logic         fifo_empty,
    output logic         fifo_rd_en,
    input  logic [139:0] fifo_rd_data,
    input  logic         ser_ready,
    output logic         ser_start,
    output logic [7:0]   ser_chan,
    output logic [7:0]   ser_len,
    output logic [127:0] ser_data,
    input  logic         ser_done,
    output logic         crc_valid_o,
    output logic         crc_err,
    output logic         timeout_err,
    output logic         busy
`ifdef SCHED_STATS_EN
    ,
    output logic [15:0]  frames_sent_o,
    output logic [15:0]  frames_dropped_o
`endif
);
    localparam int CMAX = TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam state_t POST = GAP_CYCLES == 0 ? S_IDLE : S_GAP;

    state_t state, nxt;
    frame_desc_t desc;
    logic [CW-1:0] cnt;
    logic chan_ok, drop, hs, to_hit, to_fire;
    logic [7:0] a_len;
    logic [127:0] a_data;

    frame_desc_align u_align (
        .chan(desc.chan),
        .len_code(desc.len_code),
        .payload(desc.payload),
        .chan_ok(chan_ok),
        .ser_len(a_len),
        .ser_data(a_data)
    );

    assign drop = !(desc.crc_ok && chan_ok);
    assign hs = state == S_ISSUE && ser_ready;
    assign to_hit = cnt == CW'(TIMEOUT_CYCLES - 1);
    assign to_fire = state == S_WAIT && !ser_done && to_hit;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = fifo_empty ? S_IDLE : S_RD;
            S_RD:    nxt = S_LAT;
            S_LAT:   nxt = S_CHK;
            S_CHK:   nxt = drop ? POST : S_ISSUE;
            S_ISSUE: nxt = ser_ready ? S_WAIT : S_ISSUE;
            S_WAIT:  nxt = (ser_done || to_hit) ? POST : S_WAIT;
            S_GAP:   nxt = cnt == CW'(GAP_CYCLES - 1) ? S_IDLE : S_GAP;
            default: nxt = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so every output leaves a flop.
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            desc <= '0;
            cnt <= '0;
            fifo_rd_en <= 1'b0;
            ser_start <= 1'b0;
            ser_chan <= '0;
            ser_len <= '0;
            ser_data <= '0;
            crc_valid_o <= 1'b0;
            crc_err <= 1'b0;
            timeout_err <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= nxt;
            cnt <= nxt != state ? '0 : cnt + 1'b1;
            fifo_rd_en <= nxt == S_RD;
            ser_start <= nxt == S_ISSUE;
            busy <= nxt != S_IDLE;
            crc_valid_o <= hs;
            crc_err <= state == S_CHK && !desc.crc_ok;
            timeout_err <= to_fire;
            if (state == S_LAT)
                desc <= frame_desc_t'(fifo_rd_data);
            if (state == S_CHK && !drop) begin
                ser_chan <= desc.chan;
                ser_len <= a_len;
                ser_data <= a_data;
            end
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            frames_sent_o <= '0;
            frames_dropped_o <= '0;
        end else begin
            if (hs && frames_sent_o != 16'hFFFF)
                frames_sent_o <= frames_sent_o + 16'd1;
            if (((state == S_CHK && drop) || to_fire) && frames_dropped_o != 16'hFFFF)
                frames_dropped_o <= frames_dropped_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_frame_out_scheduler.sv
// tb_frame_out_scheduler: directed frames with a scoreboard-driven monitor.
module tb_frame_out_scheduler;
    localparam int TO = 16;
    localparam int K_ISSUE = 0;
    localparam int K_CRC = 1;
    localparam int K_TO = 2;

    typedef struct {
        int           kind;
        logic [7:0]   chan;
        logic [7:0]   len;
        logic [127:0] data;
    } exp_t;

    logic clk_out = 1'b0;
    logic rst = 1'b1;
    logic fifo_empty, fifo_rd_en, ser_ready, ser_start, ser_done;
    logic crc_valid_o, crc_err, timeout_err, busy;
    logic [139:0] fifo_rd_data;
    logic [7:0] ser_chan, ser_len;
    logic [127:0] ser_data;
`ifdef SCHED_STATS_EN
    logic [15:0] frames_sent_o, frames_dropped_o;
    logic [15:0] s0, d0;
`endif

    always #5 clk_out = ~clk_out;

    frame_out_scheduler #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(2)) dut (
        .clk_out(clk_out),
        .rst(rst),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .fifo_rd_data(fifo_rd_data),
        .ser_ready(ser_ready),
        .ser_start(ser_start),
        .ser_chan(ser_chan),
        .ser_len(ser_len),
        .ser_data(ser_data),
        .ser_done(ser_done),
        .crc_valid_o(crc_valid_o),
        .crc_err(crc_err),
        .timeout_err(timeout_err),
        .busy(busy)
`ifdef SCHED_STATS_EN
        ,
        .frames_sent_o(frames_sent_o),
        .frames_dropped_o(frames_dropped_o)
`endif
    );

    int vectors = 0;
    int miscompares = 0;
    exp_t sb[$];
    logic [139:0] fq[$];
    int rd_hist[$];
    bit hold_full = 1'b1;
    bit rd_pend = 1'b0;
    int done_delay = 0;
    int cyc = 0;
    int rd_cyc = -100;
    int hs_cyc = -100;
    bit prev_hs = 1'b0;
    bit prev_start = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [139:0] mk(input logic crc, input logic [7:0] chan,
                                        input logic [2:0] lc, input logic [127:0] pl);
        return {crc, chan, lc, pl};
    endfunction

    task automatic exp_push(input int kind, input logic [7:0] chan, input logic [7:0] len,
                            input logic [127:0] data);
        exp_t e;
        e.kind = kind;
        e.chan = chan;
        e.len = len;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk_out); #1;
            n++;
        end while ((busy || sb.size() > 0 || fq.size() > 0) && n < 400);
        check(name, {126'd0, busy, sb.size() > 0}, 128'd0);
        repeat (3) @(posedge clk_out);
        #1;
    endtask

    // FIFO model: one-cycle read latency after fifo_rd_en
    initial begin
        fifo_rd_data = '0;
        fifo_empty = 1'b0;
        forever begin
            @(posedge clk_out); #1;
            if (rd_pend && fq.size() > 0) fifo_rd_data = fq.pop_front();
            rd_pend = fifo_rd_en;
            fifo_empty = hold_full ? 1'b0 : (fq.size() == 0);
        end
    end

    // Serializer model: ser_done done_delay cycles into WAIT, never if negative
    initial begin
        int d;
        ser_done = 1'b0;
        forever begin
            @(negedge clk_out);
            if (!rst && ser_start && ser_ready) begin
                d = done_delay;
                @(posedge clk_out); #1;
                if (d >= 0) begin
                    repeat (d) begin
                        @(posedge clk_out); #1;
                    end
                    ser_done = 1'b1;
                    @(posedge clk_out); #1;
                    ser_done = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every presented output event against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_out);
            cyc++;
            if (!rst) begin
                if (fifo_rd_en) begin
                    rd_cyc = cyc;
                    rd_hist.push_back(cyc);
                end
                if (crc_valid_o || prev_hs) check("crc_valid_pulse", crc_valid_o, prev_hs);
                if (ser_start && !prev_start) check("start_latency", cyc - rd_cyc, 3);
                if (ser_start) begin
                    if (sb.size() > 0 && sb[0].kind == K_ISSUE) begin
                        check("ser_chan", ser_chan, sb[0].chan);
                        check("ser_len", ser_len, sb[0].len);
                        check("ser_data", ser_data, sb[0].data);
                        if (ser_ready) begin
                            hs_cyc = cyc;
                            e = sb.pop_front();
                        end
                    end else check("issue_expected", 1, 0);
                end
                if (crc_err) begin
                    if (sb.size() > 0 && sb[0].kind == K_CRC) begin
                        check("crc_err_latency", cyc - rd_cyc, 3);
                        e = sb.pop_front();
                    end else check("crc_err_expected", 1, 0);
                end
                if (timeout_err) begin
                    if (sb.size() > 0 && sb[0].kind == K_TO) begin
                        check("timeout_latency", cyc - hs_cyc, TO + 1);
                        e = sb.pop_front();
                    end else check("timeout_expected", 1, 0);
                end
            end
            prev_hs = !rst && ser_start && ser_ready;
            prev_start = !rst && ser_start;
        end
    end

    initial begin
        int n;
        ser_ready = 1'b1;
        repeat (3) @(negedge clk_out);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_ser_start", ser_start, 0);
        check("rst_ser_chan", ser_chan, 0);
        check("rst_ser_len", ser_len, 0);
        check("rst_ser_data", ser_data, 0);
        check("rst_pulses", {crc_valid_o, crc_err, timeout_err}, 0);
        check("rst_busy", busy, 0);
`ifdef SCHED_STATS_EN
        check("rst_stats", {frames_sent_o, frames_dropped_o}, 0);
`endif
        hold_full = 1'b0;
        repeat (2) @(posedge clk_out);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk_out);

        // single valid frame, exact cycle positions relative to N
        @(negedge clk_out);
        exp_push(K_ISSUE, 8'h01, 8'd16, 128'hA55A << 112);
        fq.push_back(mk(1'b1, 8'h01, 3'd0, 128'hA55A));
        @(posedge clk_out); #1; check("rd_en_n", fifo_rd_en, 0);
        @(posedge clk_out); #1; check("rd_en_n1", fifo_rd_en, 1);
        @(posedge clk_out); #1; check("rd_en_n2", fifo_rd_en, 0);
        @(posedge clk_out); #1; check("start_n3", ser_start, 0);
        @(posedge clk_out); #1; check("start_n4", ser_start, 1);
        @(posedge clk_out); #1; check("crc_valid_n5", crc_valid_o, 1);
        @(posedge clk_out); #1;
        @(posedge clk_out); #1; check("busy_gap2", busy, 1);
        @(posedge clk_out); #1; check("busy_idle", busy, 0);
        wait_idle("single_idle");

        // CRC failure
        @(negedge clk_out);
        exp_push(K_CRC, 8'h02, 8'd16, 128'd0);
        fq.push_back(mk(1'b0, 8'h02, 3'd0, 128'h1111));
        wait_idle("crc_idle");
`ifdef SCHED_STATS_EN
        check("dropped_after_crc", frames_dropped_o, 1);
`endif

        // backpressure
        ser_ready = 1'b0;
        @(negedge clk_out);
        exp_push(K_ISSUE, 8'h04, 8'd64, 128'h1234_5678_9ABC_DEF0 << 64);
        fq.push_back(mk(1'b1, 8'h04, 3'd3, 128'h1234_5678_9ABC_DEF0));
        n = 0;
        do begin
            @(posedge clk_out); #1;
            n++;
        end while (!ser_start && n < 40);
        check("bp_start_seen", ser_start, 1);
        repeat (10) @(posedge clk_out);
        #1 check("bp_start_held", ser_start, 1);
        ser_ready = 1'b1;
        wait_idle("bp_idle");

        // timeout, then a queued frame issues normally
        done_delay = -1;
        @(negedge clk_out);
        exp_push(K_ISSUE, 8'h08, 8'd32, 128'hBEEF_CAFE << 96);
        exp_push(K_TO, 8'h00, 8'd0, 128'd0);
        exp_push(K_ISSUE, 8'h20, 8'd48, 128'h0123_4567_89AB << 80);
        fq.push_back(mk(1'b1, 8'h08, 3'd1, 128'hBEEF_CAFE));
        fq.push_back(mk(1'b1, 8'h20, 3'd2, 128'h0123_4567_89AB));
        n = 0;
        do begin
            @(posedge clk_out); #1;
            n++;
        end while (!crc_valid_o && n < 40);
        check("to_crc_valid_seen", crc_valid_o, 1);
        done_delay = 0;
        wait_idle("timeout_idle");

        // ser_done coincident with the last count: no timeout_err
        done_delay = TO - 1;
        @(negedge clk_out);
        exp_push(K_ISSUE, 8'h40, 8'd80, 128'hFACE << 48);
        fq.push_back(mk(1'b1, 8'h40, 3'd4, 128'hFACE));
        wait_idle("coincident_idle");

        // back-to-back: issue, silent multi-hot drop, issue
        done_delay = 0;
`ifdef SCHED_STATS_EN
        s0 = frames_sent_o;
        d0 = frames_dropped_o;
`endif
        @(negedge clk_out);
        rd_hist.delete();
        exp_push(K_ISSUE, 8'h80, 8'd128, {4{32'hDEAD_0001}});
        exp_push(K_ISSUE, 8'h10, 8'd128, {4{32'h7777_0003}});
        fq.push_back(mk(1'b1, 8'h80, 3'd7, {4{32'hDEAD_0001}}));
        fq.push_back(mk(1'b1, 8'h11, 3'd7, {4{32'h5555_0002}}));
        fq.push_back(mk(1'b1, 8'h10, 3'd7, {4{32'h7777_0003}}));
        wait_idle("b2b_idle");
        check("b2b_reads", rd_hist.size(), 3);
        if (rd_hist.size() == 3) begin
            check("b2b_spacing_issue", rd_hist[1] - rd_hist[0], 8);
            check("b2b_spacing_drop", rd_hist[2] - rd_hist[1], 6);
        end
`ifdef SCHED_STATS_EN
        check("b2b_sent", frames_sent_o - s0, 2);
        check("b2b_dropped", frames_dropped_o - d0, 1);
`endif
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
